dft_frame_gen: RTL
==================

# dft_frame_gen

Synthesizable frame sequencer placed in front of the mixed-radix DFT core. It accepts an unframed complex sample stream, buffers it in an internal FIFO, and emits complete frames of a run-time-selected DFT length on the core's sink interface. Each frame carries sop/eop markers and the per-frame `dftpts`/`inverse` sideband, and a programmable inter-frame gap is inserted between frames. Downstream `sink_ready` backpressure is honoured. A frame is started only when all of its samples are already buffered, so it is never starved mid-frame.

## Interface
Parameters:
- `DW`, 18 — sample width per component (real/imag).
- `PTS_W`, 12 — width of DFT length fields.
- `MAX_PTS`, 1200 — largest legal DFT length.
- `DEPTH`, 2048 — FIFO depth in samples; power of two, must be ≥ `MAX_PTS`.
- `GAP_W`, 16 — width of gap configuration.

Ports:
- `clk`  in  1 — single clock, all logic on rising edge.
- `rst`  in  1 — synchronous reset, active-high.
- `in_valid`  in  1 — input sample valid.
- `in_ready`  out  1 — FIFO not full.
- `in_real`, `in_imag`  in  DW each — input sample.
- `flush`  in  1 — discard buffered samples (see Operation).
- `dftpts_cfg`  in  PTS_W — DFT length for the next frame.
- `inverse_cfg`  in  1 — inverse flag for the next frame.
- `gap_cfg`  in  GAP_W — extra idle cycles between frames.
- `sink_valid`, `sink_sop`, `sink_eop`  out  1 each — frame framing to the DFT core.
- `sink_ready`  in  1 — DFT core accepts the sample.
- `sink_real`, `sink_imag`  out  DW each — output sample.
- `dftpts_out`  out  PTS_W — latched frame length, stable for the whole frame.
- `inverse_out`  out  1 — latched inverse flag, stable for the whole frame.
- `cfg_err`  out  1 — `dftpts_cfg` is illegal while in IDLE.
- `frame_cnt`  out  16 — completed frames, wraps at 0xFFFF→0.

## Operation
- FIFO: first-word-fall-through. Occupancy counter `occ` spans 0..DEPTH.
  - Write when `in_valid && in_ready`.
  - Read when a sample is loaded into the output register.
  - Simultaneous read and write leaves `occ` unchanged.
  - `in_ready = (occ != DEPTH)`.
- FSM states: IDLE, SEND, GAP.
- IDLE:
  - If `dftpts_cfg` ∈ [1, MAX_PTS] and `occ ≥ dftpts_cfg`: latch `dftpts_cfg` → `dftpts_out` and `inverse_cfg` → `inverse_out`, load the first sample with `sink_sop = 1`, set remaining count = N−1, go to SEND.
  - If `dftpts_cfg` is illegal (0 or > MAX_PTS): `cfg_err = 1` and stay in IDLE.
- SEND:
  - The output register advances only when `sink_ready` is high. While `sink_valid && !sink_ready`, all sink outputs hold.
  - Each accepted sample loads the next FIFO word. `sink_eop` marks sample N; for N = 1, sop and eop are both high on the same sample.
  - When eop is accepted: `sink_valid` drops, `frame_cnt` increments, and the gap counter loads `gap_cfg`.
  - Next state: GAP if `gap_cfg ≠ 0`, else IDLE.
  - Config inputs are ignored during SEND.
- GAP: count down to 0, then go to IDLE.
- `flush`:
  - In IDLE or GAP: empties the FIFO (`occ` → 0) in the same cycle; a coincident input write is dropped.
  - In SEND: flush is recorded and executed on the cycle eop is accepted. The current frame always completes intact.
- `rst` behaviour:
  - Outputs: all sink outputs, `dftpts_out`, `inverse_out`, `cfg_err` and `frame_cnt` reset to 0.
  - Internal state: FIFO emptied, FSM in IDLE, pending flush cleared.
  - A frame in progress is aborted with no eop.

## Timing
- Start latency: `occ` reaching N at edge E (the write of the Nth sample) gives `sink_sop`/`sink_valid` high from edge E+1. In general, sop appears one edge after the IDLE start condition is true.
- With `sink_ready` held high, a frame occupies exactly N consecutive valid cycles with no bubbles.
- Idle cycles between an eop cycle and the next sop cycle = `gap_cfg` + 1, provided data is available. The minimum is 1.
- `dftpts_out`/`inverse_out` change only on the sop load edge.
- `frame_cnt` updates on the edge that accepts eop.
- `cfg_err` is registered: it is valid one cycle after `dftpts_cfg` changes and is cleared on entering SEND.

## Test plan
- Reset, then N = 12, gap = 0, `sink_ready` = 1, 24 samples valued 1..24:
  - Frames carry 1..12 and 13..24.
  - sop is on values 1 and 13; eop is on values 12 and 24.
  - Exactly 1 idle cycle between the frames.
  - `frame_cnt` ends at 2.
- N = 1200, gap = 3000, 2400 samples pushed:
  - Second sop comes exactly 3001 cycles after the first eop.
  - `dftpts_out` = 1200 throughout both frames.
- N = 12 with `sink_ready` toggled 1,0,0,1,… during the frame:
  - Output sequence is unchanged; outputs hold while ready is low.
  - No sample is duplicated or lost.
  - eop stays on the 12th sample.
- `dftpts_cfg` = 0, then 1300, then 6, with 10 samples buffered:
  - `cfg_err` = 1 for the 0 and 1300 settings, with no sop.
  - After the change to 6, a 6-sample frame is emitted and `cfg_err` = 0.
- FIFO fill and flush:
  - Fill to DEPTH → `in_ready` = 0.
  - Assert `flush` in the middle of a frame → the frame completes to eop, then `occ` = 0.
  - A further `flush` in IDLE with a coincident input write → `occ` = 0.
- Assert `rst` at sample 5 of a 12-sample frame:
  - `sink_valid` = 0 the next cycle, `frame_cnt` = 0.
  - The next frame starts from freshly written data.

Source files
------------

// File: rtl/dft_frame_gen_if.sv
// ----------------------------------------------------------------------------
// dft_frame_gen_if
// Bundles every non-clock signal of the DFT frame sequencer:
//   - unframed input stream   : in_valid / in_ready / in_real / in_imag
//   - buffer control          : flush
//   - per-frame configuration : dftpts_cfg / inverse_cfg / gap_cfg
//   - framed sink stream      : sink_valid / sink_sop / sink_eop / sink_ready
//                               sink_real / sink_imag
//   - frame sideband / status : dftpts_out / inverse_out / cfg_err / frame_cnt
// Modports:
//   master : the surroundings of the sequencer (stream source, configuration
//            master and DFT core sink); drives inputs, observes outputs.
//   slave  : the sequencer itself.
// ----------------------------------------------------------------------------
interface dft_frame_gen_if #(
    parameter int DW    = 18,
    parameter int PTS_W = 12,
    parameter int GAP_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [DW-1:0]    in_real;
    logic [DW-1:0]    in_imag;
    logic             flush;
    logic [PTS_W-1:0] dftpts_cfg;
    logic             inverse_cfg;
    logic [GAP_W-1:0] gap_cfg;
    logic             sink_valid;
    logic             sink_sop;
    logic             sink_eop;
    logic             sink_ready;
    logic [DW-1:0]    sink_real;
    logic [DW-1:0]    sink_imag;
    logic [PTS_W-1:0] dftpts_out;
    logic             inverse_out;
    logic             cfg_err;
    logic [15:0]      frame_cnt;

    modport master (
        output in_valid, in_real, in_imag, flush,
        output dftpts_cfg, inverse_cfg, gap_cfg, sink_ready,
        input  in_ready, sink_valid, sink_sop, sink_eop, sink_real, sink_imag,
        input  dftpts_out, inverse_out, cfg_err, frame_cnt
    );

    modport slave (
        input  in_valid, in_real, in_imag, flush,
        input  dftpts_cfg, inverse_cfg, gap_cfg, sink_ready,
        output in_ready, sink_valid, sink_sop, sink_eop, sink_real, sink_imag,
        output dftpts_out, inverse_out, cfg_err, frame_cnt
    );
endinterface

// File: rtl/dft_frame_gen.sv
// ----------------------------------------------------------------------------
// dft_frame_gen
// Frame sequencer in front of the mixed-radix DFT core. Unframed complex
// samples are buffered in a first-word-fall-through FIFO; once a whole frame
// of the requested length is buffered, it is emitted on the sink interface
// with sop/eop markers and latched dftpts/inverse sideband, honouring
// sink_ready backpressure. A programmable idle gap separates frames.
// Ports:
//   clk  : single clock, rising edge
//   rst  : synchronous reset, active high
//   bus  : dft_frame_gen_if.slave (stream in, config, sink out, status)
// ----------------------------------------------------------------------------
module dft_frame_gen #(
    parameter int DW      = 18,
    parameter int PTS_W   = 12,
    parameter int MAX_PTS = 1200,
    parameter int DEPTH   = 2048,
    parameter int GAP_W   = 16
) (
    input  logic           clk,
    input  logic           rst,
    dft_frame_gen_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int OW = AW + 1;
    // common width for comparing occupancy against a frame length
    localparam int CW = (OW > PTS_W) ? OW : PTS_W;
    localparam logic [PTS_W-1:0] MAX_PTS_L = PTS_W'(MAX_PTS);
    localparam logic [OW-1:0]    DEPTH_L   = OW'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    // FIFO storage and bookkeeping; word = {imag, real}
    logic [2*DW-1:0]  r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [OW-1:0]    r_occ;

    logic             r_flush_pend;
    logic [PTS_W-1:0] r_remain;     // samples still to load after the current one
    logic [GAP_W-1:0] r_gap_cnt;

    logic             r_sink_valid;
    logic             r_sink_sop;
    logic             r_sink_eop;
    logic [DW-1:0]    r_sink_real;
    logic [DW-1:0]    r_sink_imag;
    logic [PTS_W-1:0] r_dftpts;
    logic             r_inverse;
    logic             r_cfg_err;
    logic [15:0]      r_frame_cnt;

    logic             w_cfg_legal;
    logic             w_enough;
    logic             w_start;
    logic             w_accept;
    logic             w_eop_accept;
    logic             w_load;
    logic             w_flush_now;
    logic             w_in_ready;
    logic             w_wr;
    logic [2*DW-1:0]  w_rd_data;

    assign w_cfg_legal  = (bus.dftpts_cfg != {PTS_W{1'b0}}) && (bus.dftpts_cfg <= MAX_PTS_L);
    assign w_enough     = CW'(r_occ) >= CW'(bus.dftpts_cfg);
    // flush has priority over a frame start so an emptied FIFO is never read
    assign w_start      = (r_state == ST_IDLE) && w_cfg_legal && w_enough && !bus.flush;
    assign w_accept     = (r_state == ST_SEND) && r_sink_valid && bus.sink_ready;
    assign w_eop_accept = w_accept && r_sink_eop;
    assign w_load       = w_start || (w_accept && !r_sink_eop);
    // outside SEND flush acts at once; inside SEND it waits for the eop accept
    assign w_flush_now  = ((r_state != ST_SEND) && bus.flush) ||
                          (w_eop_accept && (r_flush_pend || bus.flush));
    assign w_in_ready   = (r_occ != DEPTH_L);
    assign w_wr         = bus.in_valid && w_in_ready && !w_flush_now;
    // fall-through read: the head word is always presented combinationally
    assign w_rd_data    = r_mem[r_rd_ptr];

    // FIFO sample storage (no reset needed; occupancy guards every read)
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= {bus.in_imag, bus.in_real};
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_occ    <= {OW{1'b0}};
        end else if (w_flush_now) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_occ    <= {OW{1'b0}};
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_load) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_wr, w_load})
                2'b10:   r_occ <= r_occ + OW'(1);
                2'b01:   r_occ <= r_occ - OW'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_state_nxt = ST_SEND;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (w_eop_accept) begin
                    if (bus.gap_cfg != {GAP_W{1'b0}}) begin
                        w_state_nxt = ST_GAP;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_state_nxt = ST_SEND;
                end
            end
            ST_GAP: begin
                // the IDLE cycle that follows the gap supplies the extra idle cycle
                if (r_gap_cnt <= GAP_W'(1)) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_GAP;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // sink output register, frame sideband and frame counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sink_valid <= 1'b0;
            r_sink_sop   <= 1'b0;
            r_sink_eop   <= 1'b0;
            r_sink_real  <= {DW{1'b0}};
            r_sink_imag  <= {DW{1'b0}};
            r_dftpts     <= {PTS_W{1'b0}};
            r_inverse    <= 1'b0;
            r_remain     <= {PTS_W{1'b0}};
            r_frame_cnt  <= 16'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_sink_valid <= 1'b1;
                        r_sink_sop   <= 1'b1;
                        r_sink_eop   <= (bus.dftpts_cfg == PTS_W'(1));
                        r_sink_real  <= w_rd_data[DW-1:0];
                        r_sink_imag  <= w_rd_data[2*DW-1:DW];
                        r_dftpts     <= bus.dftpts_cfg;
                        r_inverse    <= bus.inverse_cfg;
                        r_remain     <= bus.dftpts_cfg - PTS_W'(1);
                    end
                end
                ST_SEND: begin
                    if (w_accept) begin
                        if (r_sink_eop) begin
                            r_sink_valid <= 1'b0;
                            r_sink_sop   <= 1'b0;
                            r_sink_eop   <= 1'b0;
                            r_frame_cnt  <= r_frame_cnt + 16'd1;
                        end else begin
                            r_sink_sop   <= 1'b0;
                            r_sink_eop   <= (r_remain == PTS_W'(1));
                            r_sink_real  <= w_rd_data[DW-1:0];
                            r_sink_imag  <= w_rd_data[2*DW-1:DW];
                            r_remain     <= r_remain - PTS_W'(1);
                        end
                    end
                end
                default: begin
                    r_sink_valid <= 1'b0;
                end
            endcase
        end
    end

    // configuration error flag, only meaningful while waiting in IDLE
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cfg_err <= 1'b0;
        end else if (r_state == ST_IDLE) begin
            r_cfg_err <= !w_cfg_legal;
        end else begin
            r_cfg_err <= 1'b0;
        end
    end

    // inter-frame gap counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_gap_cnt <= {GAP_W{1'b0}};
        end else if (w_eop_accept) begin
            r_gap_cnt <= bus.gap_cfg;
        end else if ((r_state == ST_GAP) && (r_gap_cnt != {GAP_W{1'b0}})) begin
            r_gap_cnt <= r_gap_cnt - GAP_W'(1);
        end
    end

    // flush requested during a frame is held until that frame's eop is accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            r_flush_pend <= 1'b0;
        end else if (r_state == ST_SEND) begin
            if (w_eop_accept) begin
                r_flush_pend <= 1'b0;
            end else if (bus.flush) begin
                r_flush_pend <= 1'b1;
            end
        end else begin
            r_flush_pend <= 1'b0;
        end
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.sink_valid  = r_sink_valid;
    assign bus.sink_sop    = r_sink_sop;
    assign bus.sink_eop    = r_sink_eop;
    assign bus.sink_real   = r_sink_real;
    assign bus.sink_imag   = r_sink_imag;
    assign bus.dftpts_out  = r_dftpts;
    assign bus.inverse_out = r_inverse;
    assign bus.cfg_err     = r_cfg_err;
    assign bus.frame_cnt   = r_frame_cnt;

endmodule
